// File: rtl/sr04_echo_responder.sv
// HC-SR04 sensor model: answers a valid trigger pulse with an echo whose width encodes distance_cm.
// Latency: echo rises BURST+1 cycles after the synchronised trigger falls (plus 2 cycles of synchroniser).
// No backpressure: triggers arriving while busy are dropped and flagged on ignored_trig.
module sr04_echo_responder #(
    parameter int unsigned CLKS_PER_US = 100,
    parameter int unsigned US_PER_CM   = 58,
    parameter int unsigned MIN_TRIG_US = 10,
    parameter int unsigned BURST_US    = 250,
    parameter int unsigned TIMEOUT_US  = 38000,
    parameter int unsigned MAX_DIST_CM = 400,
    parameter int unsigned HOLDOFF_US  = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trigger,
    input  logic [11:0] distance_cm,
    output logic        echo,
    output logic        busy,
    output logic        short_trig,
    output logic        ignored_trig,
    output logic [15:0] echo_count
);

    // All limits in clock cycles, 32-bit unsigned
    localparam logic [31:0] MIN_CYC     = 32'(MIN_TRIG_US * CLKS_PER_US);
    localparam logic [31:0] BURST_CYC   = 32'(BURST_US * CLKS_PER_US);
    localparam logic [31:0] TIMEOUT_CYC = 32'(TIMEOUT_US * CLKS_PER_US);
    localparam logic [31:0] HOLDOFF_CYC = 32'(HOLDOFF_US * CLKS_PER_US);
    localparam logic [31:0] CM_CYC      = 32'(US_PER_CM * CLKS_PER_US);
    localparam logic [31:0] MAX_DIST    = 32'(MAX_DIST_CM);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRIG_HI = 3'd1,
        S_BURST   = 3'd2,
        S_ECHO    = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cnt;
    logic [31:0] width_lat;
    logic [31:0] width_calc;
    logic [31:0] dist_ext;
    logic        trig_meta;
    logic        trig_s;
    logic        trig_prev;
    logic        trig_rise;
    logic        trig_fall;
    logic        in_service;

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            trig_meta <= trigger;
            trig_s    <= trig_meta;
            trig_prev <= trig_s;
        end
    end

    assign trig_rise  = trig_s & ~trig_prev;
    assign trig_fall  = ~trig_s & trig_prev;
    assign in_service = (state == S_BURST) || (state == S_ECHO) || (state == S_HOLDOFF);

    // Echo width for the current distance input; zero or out-of-range reports the timeout width
    always_comb begin
        dist_ext = {20'd0, distance_cm};
        if ((dist_ext == 32'd0) || (dist_ext > MAX_DIST)) begin
            width_calc = TIMEOUT_CYC;
        end else begin
            width_calc = dist_ext * CM_CYC;
        end
    end

    // State register; echo and busy are registered from the next state so they never glitch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            echo  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            echo  <= (state_nxt == S_ECHO);
            busy  <= (state_nxt != S_IDLE);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (trig_rise) state_nxt = S_TRIG_HI;
            end
            S_TRIG_HI: begin
                if (trig_fall) state_nxt = (cnt >= MIN_CYC) ? S_BURST : S_IDLE;
            end
            S_BURST: begin
                if (cnt == BURST_CYC - 32'd1) state_nxt = S_ECHO;
            end
            S_ECHO: begin
                if (cnt == width_lat - 32'd1) state_nxt = S_HOLDOFF;
            end
            S_HOLDOFF: begin
                if (cnt == HOLDOFF_CYC - 32'd1) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Cycle counter, latched echo width and completed-echo counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= 32'd0;
            width_lat  <= 32'd0;
            echo_count <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The edge cycle is the first high cycle, so it already counts as one
                    cnt <= trig_rise ? 32'd1 : 32'd0;
                end
                S_TRIG_HI: begin
                    if (trig_fall) begin
                        cnt <= 32'd0;
                        // Latching the derived width is equivalent to latching distance_cm
                        if (cnt >= MIN_CYC) width_lat <= width_calc;
                    end else if (trig_s && (cnt < MIN_CYC)) begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_BURST, S_ECHO, S_HOLDOFF: begin
                    cnt <= (state_nxt != state) ? 32'd0 : cnt + 32'd1;
                end
                default: cnt <= 32'd0;
            endcase
            if ((state == S_ECHO) && (state_nxt == S_HOLDOFF)) begin
                echo_count <= echo_count + 16'd1;
            end
        end
    end

    // Single-cycle status pulses
    always_comb begin
        short_trig   = (state == S_TRIG_HI) && trig_fall && (cnt < MIN_CYC);
        ignored_trig = trig_rise && in_service;
    end

endmodule

// File: tb/tb_sr04_echo_responder.sv
// Bench for sr04_echo_responder with scaled-down timing parameters.
// Table-driven single triggers, hand-written corner sequences, then a randomized stream
// checked against an event-level model of the trigger/echo protocol.
module tb_sr04_echo_responder;

    localparam int CPU      = 2;
    localparam int UPC      = 3;
    localparam int MIN_US   = 10;
    localparam int BURST_US = 25;
    localparam int TO_US    = 1500;
    localparam int MAXD     = 400;
    localparam int HOLD_US  = 40;
    localparam int MIN_C    = MIN_US * CPU;
    localparam int BURST_C  = BURST_US * CPU;
    localparam int HOLD_C   = HOLD_US * CPU;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trigger = 1'b0;
    logic [11:0] distance_cm = 12'd0;
    logic        echo;
    logic        busy;
    logic        short_trig;
    logic        ignored_trig;
    logic [15:0] echo_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int exp_count = 0;

    sr04_echo_responder #(
        .CLKS_PER_US(CPU), .US_PER_CM(UPC), .MIN_TRIG_US(MIN_US), .BURST_US(BURST_US),
        .TIMEOUT_US(TO_US), .MAX_DIST_CM(MAXD), .HOLDOFF_US(HOLD_US)
    ) dut (
        .clk(clk), .reset_n(reset_n), .trigger(trigger), .distance_cm(distance_cm),
        .echo(echo), .busy(busy), .short_trig(short_trig), .ignored_trig(ignored_trig),
        .echo_count(echo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation of DUT outputs on the falling edge
    int   rise_cyc = 0;
    logic echo_q = 1'b0;
    int   obs_rise[$];
    int   obs_width[$];
    int   n_short = 0;
    int   n_ign = 0;
    int   n_busy = 0;

    always @(negedge clk) begin
        if (echo && !echo_q) rise_cyc = cyc;
        if (!echo && echo_q) begin
            obs_rise.push_back(rise_cyc);
            obs_width.push_back(cyc - rise_cyc);
        end
        echo_q = echo;
        if (short_trig) n_short++;
        if (ignored_trig) n_ign++;
        if (busy) n_busy++;
    end

    function automatic int exp_width(input int d);
        if (d == 0 || d > MAXD) return TO_US * CPU;
        return d * UPC * CPU;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Trigger pin high for h cycles; p is the cycle the pin went high
    task automatic drive_pulse(input int h, input int d, output int p);
        @(posedge clk);
        #1;
        distance_cm = 12'(d);
        trigger = 1'b1;
        p = cyc;
        repeat (h) @(posedge clk);
        #1 trigger = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < limit) begin
            @(negedge clk);
            n++;
            if (busy) quiet = 0; else quiet++;
        end
        #1;
        check("idle_reached", int'(quiet >= 4), 1);
    endtask

    task automatic wait_echo(input int limit);
        int n = 0;
        while (!echo && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("echo_seen", int'(echo), 1);
    endtask

    typedef struct {
        int h;
        int d;
        int n_echo;
        int width;
        int lat;
        int n_sh;
        int busy_cyc;
    } vec_t;

    vec_t vt[9];

    initial begin
        int p, p2, s0, i0, b0, gap, h, d, r, w, c, free_at, exp_sh, exp_ig, sel;
        int exp_rise[$];
        int exp_w[$];

        // h, d, echoes, width, latency from pin rise, short pulses, busy cycles
        vt[0] = '{24, 100, 1, 600, 77, 0, 754};
        vt[1] = '{10, 100, 0, 0, 0, 1, 10};
        vt[2] = '{24, 0, 1, 3000, 77, 0, 3154};
        vt[3] = '{24, 401, 1, 3000, 77, 0, 3154};
        vt[4] = '{20, 2, 1, 12, 73, 0, 162};
        vt[5] = '{19, 2, 0, 0, 0, 1, 19};
        vt[6] = '{24, 400, 1, 2400, 77, 0, 2554};
        vt[7] = '{30, 1, 1, 6, 83, 0, 166};
        vt[8] = '{1, 5, 0, 0, 0, 1, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_echo", int'(echo), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_short", int'(short_trig), 0);
        check("rst_ignored", int'(ignored_trig), 0);
        check("rst_count", int'(echo_count), 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table of single triggers from idle
        for (int i = 0; i < 9; i++) begin
            obs_rise.delete();
            obs_width.delete();
            s0 = n_short;
            b0 = n_busy;
            drive_pulse(vt[i].h, vt[i].d, p);
            wait_idle(8000);
            check($sformatf("row%0d_echoes", i), obs_rise.size(), vt[i].n_echo);
            if (obs_rise.size() > 0 && vt[i].n_echo > 0) begin
                check($sformatf("row%0d_width", i), obs_width[0], vt[i].width);
                check($sformatf("row%0d_latency", i), obs_rise[0] - p, vt[i].lat);
            end
            check($sformatf("row%0d_short", i), n_short - s0, vt[i].n_sh);
            check($sformatf("row%0d_busy", i), n_busy - b0, vt[i].busy_cyc);
            exp_count += vt[i].n_echo;
            check($sformatf("row%0d_count", i), int'(echo_count), exp_count);
        end

        // Second trigger during an echo is ignored
        obs_rise.delete();
        obs_width.delete();
        i0 = n_ign;
        drive_pulse(24, 100, p);
        wait_echo(500);
        repeat (200) @(negedge clk);
        drive_pulse(24, 55, p2);
        wait_idle(8000);
        check("ign_pulses", n_ign - i0, 1);
        check("ign_echoes", obs_rise.size(), 1);
        if (obs_width.size() > 0) check("ign_width", obs_width[0], 600);
        exp_count += 1;
        check("ign_count", int'(echo_count), exp_count);

        // Distance changed during BURST has no effect
        obs_rise.delete();
        obs_width.delete();
        drive_pulse(24, 100, p);
        #1 distance_cm = 12'd20;
        check("latch_in_burst", int'(busy && !echo), 1);
        wait_idle(8000);
        check("latch_echoes", obs_rise.size(), 1);
        if (obs_width.size() > 0) check("latch_width", obs_width[0], 600);
        exp_count += 1;

        // Trigger held high: stays busy without echo until release
        obs_rise.delete();
        obs_width.delete();
        @(posedge clk);
        #1 distance_cm = 12'd10;
        trigger = 1'b1;
        repeat (300) @(negedge clk);
        check("held_busy", int'(busy), 1);
        check("held_no_echo", obs_rise.size() + int'(echo), 0);
        @(posedge clk);
        #1 trigger = 1'b0;
        wait_idle(8000);
        check("held_echoes", obs_rise.size(), 1);
        if (obs_width.size() > 0) check("held_width", obs_width[0], 60);
        exp_count += 1;

        // Trigger rising in HOLDOFF and still high afterwards is not accepted
        obs_rise.delete();
        obs_width.delete();
        drive_pulse(24, 1, p);
        wait_echo(500);
        repeat (20) @(negedge clk);
        i0 = n_ign;
        s0 = n_short;
        @(posedge clk);
        #1 trigger = 1'b1;
        repeat (200) @(negedge clk);
        check("hold_busy_after", int'(busy), 0);
        check("hold_ign", n_ign - i0, 1);
        check("hold_echoes", obs_rise.size(), 1);
        @(posedge clk);
        #1 trigger = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_release_busy", int'(busy), 0);
        check("hold_release_short", n_short - s0, 0);
        exp_count += 1;
        check("hold_count", int'(echo_count), exp_count);

        // Randomized trigger stream against the event model
        obs_rise.delete();
        obs_width.delete();
        s0 = n_short;
        i0 = n_ign;
        free_at = 0;
        exp_sh = 0;
        exp_ig = 0;
        for (int k = 0; k < 24; k++) begin
            gap = $urandom_range(0, 300);
            repeat (gap) @(posedge clk);
            h = $urandom_range(1, 40);
            sel = $urandom_range(0, 9);
            if (sel == 0) d = 0;
            else if (sel == 1) d = $urandom_range(401, 4095);
            else if (sel == 2) d = $urandom_range(380, 400);
            else d = $urandom_range(1, 60);
            drive_pulse(h, d, p);
            c = p + 2;  // synchroniser delay to the detected edge
            if (c >= free_at) begin
                if (h < MIN_C) begin
                    exp_sh++;
                    free_at = c + h + 1;
                end else begin
                    r = p + h + BURST_C + 3;
                    w = exp_width(d);
                    exp_rise.push_back(r);
                    exp_w.push_back(w);
                    free_at = r + w + HOLD_C;
                end
            end else begin
                exp_ig++;
            end
        end
        wait_idle(8000);
        check("rnd_echoes", obs_rise.size(), exp_rise.size());
        for (int j = 0; j < exp_rise.size() && j < obs_rise.size(); j++) begin
            check($sformatf("rnd%0d_rise", j), obs_rise[j], exp_rise[j]);
            check($sformatf("rnd%0d_width", j), obs_width[j], exp_w[j]);
        end
        check("rnd_short", n_short - s0, exp_sh);
        check("rnd_ignored", n_ign - i0, exp_ig);
        exp_count += exp_rise.size();
        check("rnd_count", int'(echo_count), exp_count);

        // Reset mid-echo drops echo at once; operation resumes afterwards
        drive_pulse(24, 100, p);
        wait_echo(500);
        repeat (100) @(negedge clk);
        check("pre_reset_echo", int'(echo), 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_reset_echo", int'(echo), 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_count", int'(echo_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        obs_rise.delete();
        obs_width.delete();
        drive_pulse(20, 2, p);
        wait_idle(8000);
        check("post_reset_echoes", obs_rise.size(), 1);
        if (obs_rise.size() > 0) begin
            check("post_reset_width", obs_width[0], 12);
            check("post_reset_latency", obs_rise[0] - p, 73);
        end
        check("post_reset_count", int'(echo_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
